// File: rtl/pwm_multi_gen_if.sv
// Configuration and status bundle for pwm_multi_gen.
// Configuration is flat register buses; the outputs are all registered inside the core.
interface pwm_multi_gen_if #(
   parameter int unsigned NUM_GEN    = 2,
   parameter int unsigned CH_PER_GEN = 2,
   parameter int unsigned NUM_OUT    = 8,
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned DIV_W      = 4
);
   localparam int unsigned NCH   = NUM_GEN * CH_PER_GEN;
   localparam int unsigned SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

   logic [NUM_GEN-1:0]         gen_enable;
   logic [NUM_GEN-1:0]         gen_center;
   logic [NUM_GEN*DIV_W-1:0]   gen_div_exp;
   logic [NUM_GEN*CNT_W-1:0]   gen_period;
   logic [NCH*CNT_W-1:0]       ch_duty;
   logic [NCH-1:0]             ch_invert;
   logic [NUM_GEN-1:0]         update_req;
   logic [NUM_OUT-1:0]         out_en;
   logic [NUM_OUT-1:0]         out_pwm_en;
   logic [NUM_OUT*SEL_W-1:0]   out_sel;
   logic [NUM_GEN-1:0]         update_pending;
   logic [NUM_GEN-1:0]         period_start;
   logic [NUM_OUT-1:0]         out;

   modport master (
      output gen_enable, gen_center, gen_div_exp, gen_period, ch_duty, ch_invert,
             update_req, out_en, out_pwm_en, out_sel,
      input  update_pending, period_start, out
   );

   modport slave (
      input  gen_enable, gen_center, gen_div_exp, gen_period, ch_duty, ch_invert,
             update_req, out_en, out_pwm_en, out_sel,
      output update_pending, period_start, out
   );
endinterface

// File: rtl/pwm_multi_gen.sv
// Multi-timebase PWM engine: prescaled edge/centre counters, double-buffered compare
// channels and a registered per-pin crossbar.
module pwm_multi_gen #(
   parameter int unsigned NUM_GEN    = 2,
   parameter int unsigned CH_PER_GEN = 2,
   parameter int unsigned NUM_OUT    = 8,
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned DIV_W      = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   pwm_multi_gen_if.slave bus
);
   localparam int unsigned NCH   = NUM_GEN * CH_PER_GEN;
   localparam int unsigned SEL_W = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned PRE_W = (1 << DIV_W) - 1;

   logic [NUM_GEN-1:0][PRE_W-1:0] presc_q, presc_d;
   logic [NUM_GEN-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [NUM_GEN-1:0][CNT_W-1:0] per_q, per_d;
   logic [NUM_GEN-1:0][DIV_W-1:0] exp_q, exp_d;
   logic [NUM_GEN-1:0]            down_q, down_d;
   logic [NUM_GEN-1:0]            ctr_q, ctr_d;
   logic [NUM_GEN-1:0]            en_q, en_d;
   logic [NUM_GEN-1:0]            pend_q, pend_d;
   logic [NUM_GEN-1:0]            pstart_q, pstart_d;
   logic [NCH-1:0][CNT_W-1:0]     duty_q, duty_d;
   logic [NCH-1:0]                inv_q, inv_d;
   logic [NCH-1:0]                chan;
   logic [NUM_OUT-1:0]            out_q, out_d;

   always_comb begin : p_gen
      logic             live, tick, bnd, req, load, e_ctr;
      logic [CNT_W-1:0] e_per, e_duty;
      logic [DIV_W-1:0] e_exp;
      logic [PRE_W-1:0] top;
      int unsigned      idx;
      presc_d  = presc_q;
      cnt_d    = cnt_q;
      per_d    = per_q;
      exp_d    = exp_q;
      down_d   = down_q;
      ctr_d    = ctr_q;
      pend_d   = pend_q;
      pstart_d = '0;
      duty_d   = duty_q;
      inv_d    = inv_q;
      en_d     = bus.gen_enable;
      chan     = '0;
      live = 1'b0; tick = 1'b0; bnd = 1'b0; req = 1'b0; load = 1'b0; e_ctr = 1'b0;
      e_per = '0; e_duty = '0; e_exp = '0; top = '0; idx = 0;
      for (int g = 0; g < NUM_GEN; g++) begin
         // First enabled cycle runs on the live inputs, so a restart never sees stale settings.
         live  = ~en_q[g];
         e_per = live ? bus.gen_period[g*CNT_W +: CNT_W] : per_q[g];
         e_ctr = live ? bus.gen_center[g] : ctr_q[g];
         e_exp = live ? bus.gen_div_exp[g*DIV_W +: DIV_W] : exp_q[g];
         top   = (PRE_W'(1) << e_exp) - PRE_W'(1);
         tick  = (presc_q[g] == top);
         bnd   = 1'b0;
         req   = pend_q[g] | bus.update_req[g];

         for (int c = 0; c < CH_PER_GEN; c++) begin
            idx    = g * CH_PER_GEN + c;
            e_duty = live ? bus.ch_duty[idx*CNT_W +: CNT_W] : duty_q[idx];
            chan[idx] = (bus.gen_enable[g] & (cnt_q[g] < e_duty)) ^
                        (live ? bus.ch_invert[idx] : inv_q[idx]);
         end

         if (!bus.gen_enable[g]) begin
            presc_d[g] = '0;
            cnt_d[g]   = '0;
            down_d[g]  = 1'b0;
            pend_d[g]  = 1'b0;
            load       = 1'b1;
         end else begin
            presc_d[g] = tick ? '0 : presc_q[g] + PRE_W'(1);
            if (tick) begin
               if (e_per == '0) begin
                  bnd        = 1'b1;
                  cnt_d[g]   = '0;
                  down_d[g]  = 1'b0;
               end else if (!e_ctr) begin
                  bnd        = (cnt_q[g] == e_per);
                  cnt_d[g]   = bnd ? '0 : cnt_q[g] + CNT_W'(1);
                  down_d[g]  = 1'b0;
               end else if (down_q[g]) begin
                  bnd        = (cnt_q[g] == CNT_W'(1));
                  cnt_d[g]   = cnt_q[g] - CNT_W'(1);
                  down_d[g]  = ~bnd;
               end else begin
                  cnt_d[g]   = cnt_q[g] + CNT_W'(1);
                  down_d[g]  = ((cnt_q[g] + CNT_W'(1)) == e_per);
               end
            end
            load        = live | (bnd & req);
            pend_d[g]   = req & ~bnd;
            pstart_d[g] = bnd | live;
         end

         if (load) begin
            per_d[g] = bus.gen_period[g*CNT_W +: CNT_W];
            ctr_d[g] = bus.gen_center[g];
            exp_d[g] = bus.gen_div_exp[g*DIV_W +: DIV_W];
            for (int c = 0; c < CH_PER_GEN; c++) begin
               idx         = g * CH_PER_GEN + c;
               duty_d[idx] = bus.ch_duty[idx*CNT_W +: CNT_W];
               inv_d[idx]  = bus.ch_invert[idx];
            end
         end
      end
   end

   always_comb begin : p_mux
      logic [SEL_W-1:0] sel;
      out_d = '0;
      sel   = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
         sel = bus.out_sel[i*SEL_W +: SEL_W];
         if (bus.out_en[i] && bus.out_pwm_en[i]) begin
            out_d[i] = (32'(sel) < NCH) ? chan[sel] : 1'b0;
         end else begin
            out_d[i] = bus.out_en[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q  <= '0;
         cnt_q    <= '0;
         per_q    <= '0;
         exp_q    <= '0;
         down_q   <= '0;
         ctr_q    <= '0;
         en_q     <= '0;
         pend_q   <= '0;
         pstart_q <= '0;
         duty_q   <= '0;
         inv_q    <= '0;
         out_q    <= '0;
      end else begin
         presc_q  <= presc_d;
         cnt_q    <= cnt_d;
         per_q    <= per_d;
         exp_q    <= exp_d;
         down_q   <= down_d;
         ctr_q    <= ctr_d;
         en_q     <= en_d;
         pend_q   <= pend_d;
         pstart_q <= pstart_d;
         duty_q   <= duty_d;
         inv_q    <= inv_d;
         out_q    <= out_d;
      end
   end

   assign bus.update_pending = pend_q;
   assign bus.period_start   = pstart_q;
   assign bus.out            = out_q;
endmodule

// File: tb/tb_pwm_multi_gen.sv
// Self-checking bench for pwm_multi_gen: directed period tables, shadow/reset/crossbar
// sequences and randomized traffic against a phase-based reference model.
module tb_pwm_multi_gen;
   localparam int NG = 2, CPG = 2, NO = 8, CW = 8, DW = 4, NCH = 4, SW = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pwm_multi_gen_if #(.NUM_GEN(NG), .CH_PER_GEN(CPG), .NUM_OUT(NO), .CNT_W(CW),
                      .DIV_W(DW)) bus ();
   pwm_multi_gen #(.NUM_GEN(NG), .CH_PER_GEN(CPG), .NUM_OUT(NO), .CNT_W(CW), .DIV_W(DW))
      u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   // Three single-channel generators: selector value 3 has no channel behind it.
   pwm_multi_gen_if #(.NUM_GEN(3), .CH_PER_GEN(1), .NUM_OUT(NO), .CNT_W(CW),
                      .DIV_W(DW)) bus3 ();
   pwm_multi_gen #(.NUM_GEN(3), .CH_PER_GEN(1), .NUM_OUT(NO), .CNT_W(CW), .DIV_W(DW))
      u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

   int n_chk = 0;
   int n_fail = 0;

   // Reference model: position within the period counted in ticks.
   int m_pc[NG], m_ph[NG], m_per[NG], m_ctr[NG], m_exp[NG], m_duty[NCH];
   bit m_inv[NCH], m_pend[NG], m_enp[NG];
   bit [NO-1:0] e_out;
   bit [NG-1:0] e_pend, e_ps;

   typedef struct {
      bit ctr; int ex; int per; int duty; bit inv; int len; int hi;
   } vec_t;
   vec_t vecs[9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int g = 0; g < NG; g++) begin
         m_pc[g] = 0; m_ph[g] = 0; m_per[g] = 0; m_ctr[g] = 0; m_exp[g] = 0;
         m_pend[g] = 0; m_enp[g] = 0;
      end
      for (int k = 0; k < NCH; k++) begin m_duty[k] = 0; m_inv[k] = 0; end
      e_out = '0; e_pend = '0; e_ps = '0;
   endtask

   task automatic model_step();
      bit [NCH-1:0] ch;
      int p, c, ex, cnt, len, d, idx, s;
      bit en, tick, bnd, req, iv, load, pw;
      ch = '0;
      for (int g = 0; g < NG; g++) begin
         en = bus.gen_enable[g];
         if (m_enp[g]) begin p = m_per[g]; c = m_ctr[g]; ex = m_exp[g]; end
         else begin
            p  = int'(bus.gen_period[g*CW +: CW]);
            c  = int'(bus.gen_center[g]);
            ex = int'(bus.gen_div_exp[g*DW +: DW]);
         end
         cnt = (c != 0 && m_ph[g] > p) ? 2 * p - m_ph[g] : m_ph[g];
         for (int k = 0; k < CPG; k++) begin
            idx = g * CPG + k;
            d  = m_enp[g] ? m_duty[idx] : int'(bus.ch_duty[idx*CW +: CW]);
            iv = m_enp[g] ? m_inv[idx] : bus.ch_invert[idx];
            ch[idx] = (en && cnt < d) ^ iv;
         end
         load = 1'b1;
         if (!en) begin
            m_pc[g] = 0; m_ph[g] = 0; m_pend[g] = 0; e_ps[g] = 0;
         end else begin
            tick    = (m_pc[g] == (1 << ex) - 1);
            m_pc[g] = tick ? 0 : m_pc[g] + 1;
            len     = (p == 0) ? 1 : ((c != 0) ? 2 * p : p + 1);
            bnd     = tick && (m_ph[g] == len - 1);
            if (tick) m_ph[g] = (m_ph[g] + 1) % len;
            req       = m_pend[g] | bus.update_req[g];
            load      = !m_enp[g] || (bnd && req);
            m_pend[g] = req && !bnd;
            e_ps[g]   = bnd || !m_enp[g];
         end
         if (load) begin
            m_per[g] = int'(bus.gen_period[g*CW +: CW]);
            m_ctr[g] = int'(bus.gen_center[g]);
            m_exp[g] = int'(bus.gen_div_exp[g*DW +: DW]);
            for (int k = 0; k < CPG; k++) begin
               idx = g * CPG + k;
               m_duty[idx] = int'(bus.ch_duty[idx*CW +: CW]);
               m_inv[idx]  = bus.ch_invert[idx];
            end
         end
         e_pend[g] = m_pend[g];
         m_enp[g]  = en;
      end
      for (int i = 0; i < NO; i++) begin
         en = bus.out_en[i]; pw = bus.out_pwm_en[i];
         s  = int'(bus.out_sel[i*SW +: SW]);
         e_out[i] = (en && pw) ? ((s < NCH) ? ch[s] : 1'b0) : en;
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      @(negedge clk);
      chk("model out", 64'(bus.out), 64'(e_out));
      chk("model pending", 64'(bus.update_pending), 64'(e_pend));
      chk("model period_start", 64'(bus.period_start), 64'(e_ps));
   endtask

   task automatic cfg_gen(input int g, input bit ctr, input int ex, input int per);
      bus.gen_center[g]            = ctr;
      bus.gen_div_exp[g*DW +: DW]  = DW'(ex);
      bus.gen_period[g*CW +: CW]   = CW'(per);
   endtask

   task automatic cfg_ch(input int idx, input int duty, input bit inv);
      bus.ch_duty[idx*CW +: CW] = CW'(duty);
      bus.ch_invert[idx]        = inv;
   endtask

   task automatic cfg_pin(input int i, input bit en, input bit pw, input int sel);
      bus.out_en[i] = en; bus.out_pwm_en[i] = pw; bus.out_sel[i*SW +: SW] = SW'(sel);
   endtask

   task automatic wait_ps(input string name);
      bit found = 1'b0;
      for (int k = 0; k < 400 && !found; k++) begin
         cycle();
         found = bus.period_start[0];
      end
      chk(name, 64'(found), 64'd1);
   endtask

   initial begin
      int hi, ps;
      bit found;
      vecs[0] = '{0, 0,   9,   3, 0,  10,   3};
      vecs[1] = '{1, 1,   4,   2, 0,  16,   6};
      vecs[2] = '{0, 0,   9,   0, 0,  10,   0};
      vecs[3] = '{0, 0, 200, 255, 0, 201, 201};
      vecs[4] = '{0, 0,   9,   3, 1,  10,   7};
      vecs[5] = '{0, 0,   0,   1, 0,   1,   1};
      vecs[6] = '{0, 2,   0,   0, 1,   4,   4};
      vecs[7] = '{1, 0,   3,   3, 0,   6,   5};
      vecs[8] = '{0, 2,   7,   4, 0,  32,  16};

      bus.gen_enable = '0; bus.gen_center = '0; bus.gen_div_exp = '0; bus.gen_period = '0;
      bus.ch_duty = '0; bus.ch_invert = '0; bus.update_req = '0;
      bus.out_en = '0; bus.out_pwm_en = '0; bus.out_sel = '0;
      bus3.gen_enable = 3'b111; bus3.gen_center = '0; bus3.gen_div_exp = '0;
      bus3.gen_period = {3{8'd9}}; bus3.ch_duty = {3{8'd200}}; bus3.ch_invert = '0;
      bus3.update_req = '0; bus3.out_en = 8'h03; bus3.out_pwm_en = 8'h03;
      bus3.out_sel = 16'b10_11;
      model_reset();

      repeat (2) @(negedge clk);
      chk("reset out", 64'(bus.out), 64'd0);
      chk("reset pending", 64'(bus.update_pending), 64'd0);
      chk("reset period_start", 64'(bus.period_start), 64'd0);
      rst_n = 1'b1;

      // Period tables on generator 0 channel 0, pin 0.
      cfg_pin(0, 1'b1, 1'b1, 0);
      foreach (vecs[v]) begin
         bus.gen_enable[0] = 1'b0;
         cfg_gen(0, vecs[v].ctr, vecs[v].ex, vecs[v].per);
         cfg_ch(0, vecs[v].duty, vecs[v].inv);
         cycle(); cycle();
         bus.gen_enable[0] = 1'b1;
         repeat (2 * vecs[v].len + 3) cycle();
         hi = 0; ps = 0;
         repeat (vecs[v].len) begin
            cycle();
            hi += int'(bus.out[0]);
            ps += int'(bus.period_start[0]);
         end
         chk($sformatf("vec%0d high clocks", v), 64'(hi), 64'(vecs[v].hi));
         chk($sformatf("vec%0d period_start", v), 64'(ps), 64'd1);
      end

      // Shadow update mid-period: old duty holds until the boundary.
      bus.gen_enable[0] = 1'b0;
      cfg_gen(0, 1'b0, 0, 9);
      cfg_ch(0, 3, 1'b0);
      cycle();
      bus.gen_enable[0] = 1'b1;
      cycle();
      wait_ps("shadow sync");
      repeat (5) cycle();
      cfg_ch(0, 7, 1'b0);
      bus.update_req[0] = 1'b1;
      cycle();
      bus.update_req[0] = 1'b0;
      chk("shadow pending set", 64'(bus.update_pending[0]), 64'd1);
      hi = 0; found = 1'b0;
      for (int k = 0; k < 30 && !found; k++) begin
         cycle();
         found = bus.period_start[0];
         if (!found) hi += int'(bus.out[0]);
      end
      chk("shadow boundary seen", 64'(found), 64'd1);
      chk("shadow no runt", 64'(hi), 64'd0);
      chk("shadow pending clear", 64'(bus.update_pending[0]), 64'd0);
      hi = int'(bus.out[0]);
      repeat (9) begin cycle(); hi += int'(bus.out[0]); end
      chk("shadow new duty", 64'(hi), 64'd7);

      // Crossbar: pin5 follows gen1 ch1, pin6 static high, pin7 pwm but not enabled.
      bus.gen_enable[1] = 1'b0;
      cfg_gen(1, 1'b0, 0, 9);
      cfg_ch(3, 5, 1'b0);
      cfg_pin(5, 1'b1, 1'b1, 3);
      cfg_pin(6, 1'b1, 1'b0, 0);
      cfg_pin(7, 1'b0, 1'b1, 0);
      cycle();
      bus.gen_enable[1] = 1'b1;
      repeat (25) cycle();
      hi = 0;
      repeat (10) begin cycle(); hi += int'(bus.out[5]); end
      chk("xbar pin5 high clocks", 64'(hi), 64'd5);
      chk("xbar pin6 static", 64'(bus.out[6]), 64'd1);
      chk("xbar pin7 disabled", 64'(bus.out[7]), 64'd0);
      chk("xbar sel out of range", 64'(bus3.out[0]), 64'd0);
      chk("xbar sel gen2", 64'(bus3.out[1]), 64'd1);

      // Asynchronous reset mid-period.
      cfg_ch(0, 8, 1'b0);
      bus.update_req[0] = 1'b1;
      cycle();
      bus.update_req[0] = 1'b0;
      wait_ps("reset sync");
      repeat (5) cycle();
      chk("pre-reset out0", 64'(bus.out[0]), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset out", 64'(bus.out), 64'd0);
      chk("async reset pending", 64'(bus.update_pending), 64'd0);
      chk("async reset period_start", 64'(bus.period_start), 64'd0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cycle();
      chk("restart period_start", 64'(bus.period_start[0]), 64'd1);

      // Randomized traffic against the model.
      for (int n = 0; n < 2500; n++) begin
         bus.update_req = '0;
         for (int g = 0; g < NG; g++) begin
            if ($urandom_range(99) < 2) bus.gen_enable[g] = ($urandom_range(4) != 0);
            if ($urandom_range(99) < 6) begin
               cfg_gen(g, 1'($urandom_range(1)), $urandom_range(2), $urandom_range(12));
               for (int k = 0; k < CPG; k++)
                  cfg_ch(g * CPG + k, $urandom_range(14), 1'($urandom_range(1)));
            end
            if ($urandom_range(99) < 10) bus.update_req[g] = 1'b1;
         end
         if ($urandom_range(99) < 3) begin
            for (int i = 0; i < NO; i++)
               cfg_pin(i, ($urandom_range(7) != 0), 1'($urandom_range(1)), $urandom_range(3));
         end
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
